// File: rtl/branch_hazard_ctrl.sv
// Branch hazard control for the D-stage comparator: tracks pending writes in E/M/W,
// stalls unresolved branches, selects forwarding sources and counts branch stalls.
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_en,
    input  logic             d_valid,
    input  logic             d_is_branch,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_wr_en,
    input  logic [4:0]       d_wr_reg,
    input  logic             d_is_load,
    output logic             stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic             cmp_judge,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       vld;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    slot_t            r_e;
    slot_t            r_m;
    slot_t            r_w;
    logic [CNT_W-1:0] r_cnt;

    slot_t            w_d_slot;
    logic             w_br;
    logic [2:0]       w_res1;
    logic [2:0]       w_res2;
    logic             w_stall;
    logic             w_sat;

    function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
        return s.vld & s.wr_en & (s.wr_reg == r) & (r != 5'd0);
    endfunction

    // Result is {stall, sel[1:0]}; M is checked before W because it is the younger producer.
    function automatic logic [2:0] resolve(input slot_t e, input slot_t m,
                                           input slot_t w, input logic [4:0] r);
        if (slot_hit(e, r)) begin
            return 3'b100;
        end else if (slot_hit(m, r)) begin
            return m.is_load ? 3'b100 : 3'b010;
        end else if (slot_hit(w, r)) begin
            return 3'b001;
        end
        return 3'b000;
    endfunction

    always_comb begin
        w_d_slot = '{vld: d_valid, wr_en: d_wr_en, wr_reg: d_wr_reg, is_load: d_is_load};
        // Gating with reset keeps every output quiet while reset is held low.
        w_br     = reset & d_valid & d_is_branch;
        w_res1   = resolve(r_e, r_m, r_w, d_rs);
        w_res2   = resolve(r_e, r_m, r_w, d_rt);
        w_stall  = w_br & (w_res1[2] | w_res2[2]);
        w_sat    = &r_cnt;
    end

    always_comb begin
        stall     = w_stall;
        cmp_judge = w_br & ~w_stall;
        fwd_sel1  = 2'b00;
        fwd_sel2  = 2'b00;
        if (w_br && !w_stall) begin
            fwd_sel1 = w_res1[1:0];
            fwd_sel2 = w_res2[1:0];
        end
        stall_cnt = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e   <= SLOT_EMPTY;
            r_m   <= SLOT_EMPTY;
            r_w   <= SLOT_EMPTY;
            r_cnt <= '0;
        end else if (pipe_en) begin
            r_w <= r_m;
            r_m <= r_e;
            // A stall holds D in place, so E receives a bubble instead of D.
            r_e <= w_stall ? SLOT_EMPTY : w_d_slot;
            if (w_stall && !w_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
